// File: rtl/c7bifu_fetch_ctl_if.sv
// BIU read-port and fetch-queue signals of the IFU fetch controller.
// master = fetch controller, slave = BIU/decode side.
interface c7bifu_fetch_ctl_if #(
    parameter int FQ_CW = 3
);
    logic             ifu_biu_rd_req;
    logic [31:0]      ifu_biu_rd_addr;
    logic             ifu_biu_cancel;
    logic             biu_ifu_rd_ack;
    logic             biu_ifu_data_valid;
    logic [31:0]      biu_ifu_data;
    logic             fq_vld;
    logic [31:0]      fq_pc;
    logic [31:0]      fq_inst;
    logic             fq_rdy;
    logic [FQ_CW-1:0] fq_count;

    modport master (
        output ifu_biu_rd_req, ifu_biu_rd_addr, ifu_biu_cancel,
        input  biu_ifu_rd_ack, biu_ifu_data_valid, biu_ifu_data,
        output fq_vld, fq_pc, fq_inst, fq_count,
        input  fq_rdy
    );

    modport slave (
        input  ifu_biu_rd_req, ifu_biu_rd_addr, ifu_biu_cancel,
        output biu_ifu_rd_ack, biu_ifu_data_valid, biu_ifu_data,
        input  fq_vld, fq_pc, fq_inst, fq_count,
        output fq_rdy
    );
endinterface

// File: rtl/c7bifu_fetch_ctl.sv
// IFU fetch controller: sequential word fetch, BIU handshake,
// PC/instruction fetch queue and redirect flush/cancel.
module c7bifu_fetch_ctl #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          FQ_DEPTH = 4,
    parameter int          FQ_CW    = $clog2(FQ_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_vld,
    input  logic [31:0]       redirect_pc,
    c7bifu_fetch_ctl_if.master bus
);
    localparam int AW = $clog2(FQ_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [31:0]      req_pc;
    logic             req;
    logic             cancel;
    logic [31:0]      pc_mem   [FQ_DEPTH];
    logic [31:0]      inst_mem [FQ_DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [FQ_CW-1:0] count;

    logic             dv;
    logic             push;
    logic             pop;
    logic [FQ_CW-1:0] cnt_nxt;
    logic             credit;
    logic [31:0]      redir_al;

    // Queue movement this cycle and the resulting fetch credit.
    always_comb begin
        dv       = bus.biu_ifu_data_valid;
        push     = (state == WAIT) & dv & ~redirect_vld;
        pop      = (count != '0) & bus.fq_rdy;
        cnt_nxt  = count + FQ_CW'(push) - FQ_CW'(pop);
        credit   = cnt_nxt < FQ_CW'(FQ_DEPTH);
        redir_al = redirect_pc & ~32'h3;
    end

    // Fetch FSM; redirect overrides every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            req      <= 1'b0;
            cancel   <= 1'b0;
        end else begin
            cancel <= 1'b0;
            if (redirect_vld) begin
                fetch_pc <= redir_al;
                req      <= 1'b0;
                unique case (state)
                    REQ: begin
                        if (bus.biu_ifu_rd_ack) begin
                            cancel <= 1'b1;
                            state  <= DROP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    WAIT: begin
                        if (dv) begin
                            state <= IDLE;
                        end else begin
                            cancel <= 1'b1;
                            state  <= DROP;
                        end
                    end
                    DROP: begin
                        if (dv) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else begin
                unique case (state)
                    IDLE: begin
                        if (fetch_en && credit) begin
                            state <= REQ;
                            req   <= 1'b1;
                        end
                    end
                    REQ: begin
                        if (bus.biu_ifu_rd_ack) begin
                            req_pc   <= fetch_pc;
                            fetch_pc <= fetch_pc + 32'd4;
                            req      <= 1'b0;
                            state    <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (dv) begin
                            if (fetch_en && credit) begin
                                state <= REQ;
                                req   <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    DROP: begin
                        if (dv) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Fetch queue: circular buffer, flushed by redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (redirect_vld) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc_mem[wptr]   <= req_pc;
                inst_mem[wptr] <= bus.biu_ifu_data;
                wptr           <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            count <= cnt_nxt;
        end
    end

    assign bus.ifu_biu_rd_req  = req;
    assign bus.ifu_biu_rd_addr = fetch_pc;
    assign bus.ifu_biu_cancel  = cancel;
    assign bus.fq_vld          = count != '0;
    assign bus.fq_pc           = pc_mem[rptr];
    assign bus.fq_inst         = inst_mem[rptr];
    assign bus.fq_count        = count;
endmodule

// File: tb/tb_c7bifu_fetch_ctl.sv
// Testbench for c7bifu_fetch_ctl: random BIU/decode stimulus,
// expected queue entries scoreboarded and checked by a monitor.
module tb_c7bifu_fetch_ctl;
    localparam logic [31:0] RST_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        redirect_vld;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    c7bifu_fetch_ctl_if #(.FQ_CW(3)) bif ();

    c7bifu_fetch_ctl #(
        .RESET_PC(RST_PC),
        .FQ_DEPTH(4),
        .FQ_CW(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch_en(fetch_en),
        .redirect_vld(redirect_vld),
        .redirect_pc(redirect_pc),
        .bus(bif)
    );

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        exp_q[$];
    bit          push_pend;
    ent_t        push_ent;
    bit          cancel_nxt;
    bit          cancel_exp;
    bit          mon_en;
    logic [31:0] m_pc;
    logic [31:0] pend_pc;
    bit          pend;
    bit          live;
    int          pend_wait;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Monitor: compares queue/cancel state, then applies the coming pop/flush.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("fq_count", 64'(bif.fq_count), 64'(exp_q.size()));
            chk("fq_vld", 64'(bif.fq_vld), 64'(exp_q.size() != 0));
            chk("cancel", 64'(bif.ifu_biu_cancel), 64'(cancel_exp));
            chk("fq_bound", 64'(exp_q.size() <= 4), 64'd1);
            if (bif.fq_vld && exp_q.size() != 0) begin
                chk("fq_pc", 64'(bif.fq_pc), 64'(exp_q[0].pc));
                chk("fq_inst", 64'(bif.fq_inst), 64'(exp_q[0].inst));
            end
            if (redirect_vld) exp_q.delete();
            else if (bif.fq_vld && bif.fq_rdy && exp_q.size() != 0)
                void'(exp_q.pop_front());
        end
    end

    // One clock of stimulus plus the reference model for the coming edge.
    // rmode: 0 none, 1 now, 2 in REQ, 3 in WAIT w/o data,
    //        4 with live data return, other: random.
    task automatic cyc(input bit fe, input int rmode, input logic [31:0] rpc,
                       input int rdy_pct, input int ack_pct, output bit fired);
        bit acc;
        bit redir;
        bit dv;
        @(posedge clk);
        #1;
        if (push_pend) begin
            exp_q.push_back(push_ent);
            push_pend = 1'b0;
        end
        cancel_exp = cancel_nxt;
        if (bif.ifu_biu_rd_req) chk("single_out", 64'(pend), 64'd0);
        dv = pend && pend_wait == 0;
        case (rmode)
            0: redir = 1'b0;
            1: redir = 1'b1;
            2: redir = bif.ifu_biu_rd_req;
            3: redir = pend && !dv && live;
            4: redir = dv && live;
            default: redir = $urandom_range(99) < 8;
        endcase
        fired = redir;
        fetch_en = fe;
        redirect_vld = redir;
        redirect_pc = rpc;
        bif.fq_rdy = redir ? 1'b1 : ($urandom_range(99) < rdy_pct);
        acc = bif.ifu_biu_rd_req && ($urandom_range(99) < ack_pct);
        bif.biu_ifu_rd_ack = acc;
        bif.biu_ifu_data_valid = dv;
        bif.biu_ifu_data = dv ? $urandom : 32'h0;
        cancel_nxt = redir && (acc || (pend && live && !dv));
        if (dv) begin
            if (live && !redir) begin
                push_pend = 1'b1;
                push_ent = {pend_pc, bif.biu_ifu_data};
            end
            pend = 1'b0;
        end else if (pend) begin
            pend_wait--;
        end
        if (acc) begin
            chk("rd_addr", 64'(bif.ifu_biu_rd_addr), 64'(m_pc));
            pend = 1'b1;
            live = !redir;
            pend_pc = m_pc;
            pend_wait = $urandom_range(0, 3);
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            m_pc = {rpc[31:2], 2'b00};
            live = 1'b0;
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_req", 64'(bif.ifu_biu_rd_req), 64'd0);
        chk("rst_addr", 64'(bif.ifu_biu_rd_addr), 64'(RST_PC));
        chk("rst_cancel", 64'(bif.ifu_biu_cancel), 64'd0);
        chk("rst_vld", 64'(bif.fq_vld), 64'd0);
        chk("rst_pc", 64'(bif.fq_pc), 64'd0);
        chk("rst_inst", 64'(bif.fq_inst), 64'd0);
        chk("rst_count", 64'(bif.fq_count), 64'd0);
    endtask

    task automatic run(input int n, input bit fe, input int rdy_pct, input int ack_pct);
        bit f;
        for (int i = 0; i < n; i++) cyc(fe, 0, 32'h0, rdy_pct, ack_pct, f);
    endtask

    task automatic redirect_when(input string name, input int rmode,
                                 input logic [31:0] rpc, input int rdy_pct,
                                 input int ack_pct);
        bit f = 1'b0;
        for (int i = 0; i < 60 && !f; i++) cyc(1'b1, rmode, rpc, rdy_pct, ack_pct, f);
        chk(name, 64'(f), 64'd1);
    endtask

    initial begin
        bit f;
        reset = 1'b1;
        fetch_en = 1'b0;
        redirect_vld = 1'b0;
        redirect_pc = 32'h0;
        bif.biu_ifu_rd_ack = 1'b0;
        bif.biu_ifu_data_valid = 1'b0;
        bif.biu_ifu_data = 32'h0;
        bif.fq_rdy = 1'b0;
        m_pc = RST_PC;
        #1;
        chk_reset_vals();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        mon_en = 1'b1;

        // Fill the queue with decode stalled; fetching must stop at 4.
        run(40, 1'b1, 0, 100);
        chk("full_count", 64'(bif.fq_count), 64'd4);
        chk("full_req_stop", 64'(bif.ifu_biu_rd_req), 64'd0);

        // One pop lets exactly one more fetch through.
        run(1, 1'b1, 100, 100);
        run(20, 1'b1, 0, 100);
        chk("refill_count", 64'(bif.fq_count), 64'd4);

        // Redirect while waiting for data: cancel and drop.
        redirect_when("to_wait", 3, 32'h1c000103, 100, 100);
        run(30, 1'b1, 100, 100);

        // Redirect in REQ without ack, then with ack.
        redirect_when("to_req_noack", 2, 32'h1c000200, 100, 0);
        run(20, 1'b1, 100, 100);
        redirect_when("to_req_ack", 2, 32'h1c000300, 100, 100);
        run(20, 1'b1, 100, 100);

        // Redirect coincident with data return and a pop.
        run(10, 1'b1, 0, 100);
        redirect_when("to_dv", 4, 32'h1c000400, 0, 100);
        run(20, 1'b1, 100, 100);

        // Fetch PC wraps past the top of the address space.
        cyc(1'b1, 1, 32'hFFFFFFFC, 100, 100, f);
        run(20, 1'b1, 100, 100);

        // Random traffic with random redirects.
        for (int i = 0; i < 500; i++)
            cyc($urandom_range(99) < 85, 5, $urandom, 60, 60, f);
        run(20, 1'b1, 100, 100);

        // Reset in the middle of a WAIT; late return must be ignored.
        f = 1'b0;
        for (int i = 0; i < 60 && !f; i++) begin
            cyc(1'b1, 0, 32'h0, 100, 100, f);
            f = pend && live && pend_wait > 0;
        end
        chk("to_rst_wait", 64'(f), 64'd1);
        mon_en = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals();
        exp_q.delete();
        push_pend = 1'b0;
        cancel_nxt = 1'b0;
        cancel_exp = 1'b0;
        m_pc = RST_PC;
        live = 1'b0;
        fetch_en = 1'b0;
        bif.biu_ifu_rd_ack = 1'b0;
        bif.biu_ifu_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 10 && pend; i++) cyc(1'b0, 0, 32'h0, 100, 100, f);
        chk("late_ret_done", 64'(pend), 64'd0);
        run(20, 1'b1, 100, 100);
        run(10, 1'b0, 100, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
